// File: rtl/zipo_mem_arbiter_pkg.sv
// Shared definitions for the IF/LS memory port arbiter.
// Access direction, FSM state and owner codes plus a width helper.
package zipo_mem_arbiter_pkg;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_own_e;

    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/zipo_arb_pick.sv
// Stateless requester pick: LS wins conflicts unless IF
// has been passed over STARVE_MAX times in a row.
module zipo_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int SW         = 3
) (
    input  logic          if_req,
    input  logic          ls_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_if,
    output logic          grant_ls
);

    logic starved;

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        unique case (1'b1)
            (if_req && !ls_req): grant_if = 1'b1;
            (!if_req && ls_req): grant_ls = 1'b1;
            (if_req && ls_req): begin
                if (starved) grant_if = 1'b1;
                else         grant_ls = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/zipo_mem_arbiter.sv
// Single 64-bit memory port shared between fetch and load/store,
// one access in flight, LS priority with IF starvation guard.
module zipo_mem_arbiter
    import zipo_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    input  logic [DATA_W-1:0] mem_read
);

    localparam int SW = width_for(STARVE_MAX);
    localparam int CW = width_for(MEM_LAT);

    arb_state_e    state;
    arb_own_e      owner;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_if;
    logic          grant_ls;

    zipo_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_cnt (starve_cnt),
        .grant_if   (grant_if),
        .grant_ls   (grant_ls)
    );

    // cnt counts down to 0; mem_read is valid in the cycle it reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            cnt        <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_ack     <= 1'b0;
            ls_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_rw     <= MEM_RD;
            mem_addr   <= '0;
            mem_write  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            mem_en    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_ack    <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    mem_rw <= MEM_RD;
                    if (grant_if) begin
                        owner      <= OWN_IF;
                        if_gnt     <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_addr   <= if_addr;
                        cnt        <= CW'(MEM_LAT);
                        starve_cnt <= '0;
                        state      <= ARB_BUSY;
                    end else if (grant_ls) begin
                        owner     <= OWN_LS;
                        ls_gnt    <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_rw    <= ls_we ? MEM_WR : MEM_RD;
                        mem_addr  <= ls_addr;
                        mem_write <= ls_wdata;
                        cnt       <= CW'(MEM_LAT);
                        state     <= ARB_BUSY;
                        if (if_req && starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (cnt == '0) begin
                        state  <= ARB_IDLE;
                        mem_rw <= MEM_RD;
                        if (owner == OWN_IF) begin
                            if_rdata  <= mem_read;
                            if_rvalid <= 1'b1;
                        end else begin
                            ls_ack <= 1'b1;
                            if (mem_rw == MEM_RD)
                                ls_rdata <= mem_read;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
